// File: rtl/gpio_port_if.sv
// gpio_bus_if: memory bus between a bus master (CPU) and the gpio_port.
//   MAB     - byte address
//   MDB_in  - write data
//   MDB_out - read data (combinational from the port)
//   MW/MR   - write/read strobes
//   BW      - 1 = byte access, 0 = word access
interface gpio_bus_if;
    logic [15:0] MAB;
    logic [15:0] MDB_in;
    logic [15:0] MDB_out;
    logic        MW;
    logic        MR;
    logic        BW;

    modport master (
        output MAB, MDB_in, MW, MR, BW,
        input  MDB_out
    );

    modport slave (
        input  MAB, MDB_in, MW, MR, BW,
        output MDB_out
    );
endinterface

// File: rtl/gpio_port.sv
// gpio_port: 8-bit memory-mapped digital I/O port feeding IOBUF pads.
// Ports:
//   MCLK, reset       - clock, synchronous active-high reset
//   bus               - memory bus (slave side)
//   pad_I/pad_T       - pad output value / tristate (1 = high-Z)
//   pad_O             - asynchronous pin level from the pad
//   pad_REN           - pull enable (pull direction follows pad_I)
//   periph_out/dir    - peripheral drive for pins with SEL0 = 1
//   periph_in         - synchronized pin level (PxIN)
//   irq               - OR of IE & IFG
module gpio_port #(
    parameter logic [15:0] BASE = 16'h0200
) (
    input  logic       MCLK,
    input  logic       reset,
    gpio_bus_if.slave  bus,
    output logic [7:0] pad_I,
    output logic [7:0] pad_T,
    input  logic [7:0] pad_O,
    output logic [7:0] pad_REN,
    input  logic [7:0] periph_out,
    input  logic [7:0] periph_dir,
    output logic [7:0] periph_in,
    output logic       irq
);
    // Word index (offset / 2) of each register.
    localparam logic [3:0] IDX_IN   = 4'd0;
    localparam logic [3:0] IDX_OUT  = 4'd1;
    localparam logic [3:0] IDX_DIR  = 4'd2;
    localparam logic [3:0] IDX_REN  = 4'd3;
    localparam logic [3:0] IDX_SEL0 = 4'd5;
    localparam logic [3:0] IDX_IV   = 4'd7;
    localparam logic [3:0] IDX_IES  = 4'd12;
    localparam logic [3:0] IDX_IE   = 4'd13;
    localparam logic [3:0] IDX_IFG  = 4'd14;

    logic [7:0] out_q, out_d, dir_q, dir_d, ren_q, ren_d, sel_q, sel_d;
    logic [7:0] ies_q, ies_d, ie_q, ie_d, ifg_q, ifg_d;
    logic [7:0] sync1_q, sync1_d, in_q, in_d, prev_q, prev_d;

    logic       hit, wr_en, iv_rd;
    logic [3:0] idx;
    logic [7:0] wdata, pend, iv_val, iv_onehot, iv_clr, edge_det, rdata;
    logic       unused_hi;

    assign unused_hi = ^bus.MDB_in[15:8];

    // The port occupies a 32-byte window starting at BASE.
    assign hit   = (bus.MAB[15:5] == BASE[15:5]);
    assign idx   = bus.MAB[4:1];
    assign wdata = bus.MDB_in[7:0];
    // Byte writes to the odd (high) byte land on nothing.
    assign wr_en = bus.MW & hit & ~(bus.BW & bus.MAB[0]);
    assign iv_rd = bus.MR & hit & (idx == IDX_IV);

    assign pend = ie_q & ifg_q;
    assign irq  = |pend;

    // Priority encoder: scan from the top so the lowest pending bit wins.
    always_comb begin
        iv_val    = 8'h00;
        iv_onehot = 8'h00;
        for (int n = 7; n >= 0; n--) begin
            if (pend[n]) begin
                iv_val    = 8'((n + 1) * 2);
                iv_onehot = 8'h01 << n;
            end
        end
    end

    assign iv_clr   = iv_onehot & {8{iv_rd}};
    assign edge_det = (ies_q & ~in_q & prev_q) | (~ies_q & in_q & ~prev_q);

    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        ren_d   = ren_q;
        sel_d   = sel_q;
        ies_d   = ies_q;
        ie_d    = ie_q;
        ifg_d   = ifg_q & ~iv_clr;
        sync1_d = pad_O;
        in_d    = sync1_q;
        prev_d  = in_q;
        if (wr_en) begin
            case (idx)
                IDX_OUT:  out_d = wdata;
                IDX_DIR:  dir_d = wdata;
                IDX_REN:  ren_d = wdata;
                IDX_SEL0: sel_d = wdata;
                IDX_IES:  ies_d = wdata;
                IDX_IE:   ie_d  = wdata;
                IDX_IFG:  ifg_d = wdata;
                default:  ;
            endcase
        end
        // A detected edge overrides any software write or clear.
        ifg_d = ifg_d | edge_det;
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            out_q   <= '0;
            dir_q   <= '0;
            ren_q   <= '0;
            sel_q   <= '0;
            ies_q   <= '0;
            ie_q    <= '0;
            ifg_q   <= '0;
            sync1_q <= '0;
            in_q    <= '0;
            prev_q  <= '0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            ren_q   <= ren_d;
            sel_q   <= sel_d;
            ies_q   <= ies_d;
            ie_q    <= ie_d;
            ifg_q   <= ifg_d;
            sync1_q <= sync1_d;
            in_q    <= in_d;
            prev_q  <= prev_d;
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (hit) begin
            case (idx)
                IDX_IN:   rdata = in_q;
                IDX_OUT:  rdata = out_q;
                IDX_DIR:  rdata = dir_q;
                IDX_REN:  rdata = ren_q;
                IDX_SEL0: rdata = sel_q;
                IDX_IV:   rdata = iv_val;
                IDX_IES:  rdata = ies_q;
                IDX_IE:   rdata = ie_q;
                IDX_IFG:  rdata = ifg_q;
                default:  rdata = 8'h00;
            endcase
        end
    end

    assign bus.MDB_out = {8'h00, rdata};

    assign pad_I     = (sel_q & periph_out) | (~sel_q & out_q);
    assign pad_T     = ~((sel_q & periph_dir) | (~sel_q & dir_q));
    assign pad_REN   = ren_q & ~dir_q & ~sel_q;
    assign periph_in = in_q;
endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed test-plan scenarios plus randomized bus/pin traffic,
// every cycle compared against a behavioural model of the port.
module tb_gpio_port;
    localparam logic [15:0] BASE = 16'h0200;

    logic       MCLK = 1'b0;
    logic       reset;
    logic [7:0] pad_I, pad_T, pad_O, pad_REN, periph_out, periph_dir, periph_in;
    logic       irq;

    gpio_bus_if bus_if();

    gpio_port #(.BASE(BASE)) dut (
        .MCLK(MCLK), .reset(reset), .bus(bus_if),
        .pad_I(pad_I), .pad_T(pad_T), .pad_O(pad_O), .pad_REN(pad_REN),
        .periph_out(periph_out), .periph_dir(periph_dir),
        .periph_in(periph_in), .irq(irq)
    );

    always #5 MCLK = ~MCLK;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: register file and the history of sampled pin levels
    // (samp[0] = most recent sample, samp[1] = PxIN, samp[2] = previous PxIN).
    logic [7:0] m_out, m_dir, m_ren, m_sel, m_ies, m_ie, m_ifg;
    logic [7:0] samp [3];

    task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] m_iv();
        for (int n = 0; n < 8; n++)
            if (m_ie[n] && m_ifg[n]) return 8'((n + 1) * 2);
        return 8'h00;
    endfunction

    function automatic logic [15:0] m_read(logic [15:0] a);
        logic [15:0] o;
        o = a - BASE;
        if (o >= 16'd32) return 16'h0000;
        case (o & 16'hFFFE)
            16'h00: return {8'h00, samp[1]};
            16'h02: return {8'h00, m_out};
            16'h04: return {8'h00, m_dir};
            16'h06: return {8'h00, m_ren};
            16'h0A: return {8'h00, m_sel};
            16'h0E: return {8'h00, m_iv()};
            16'h18: return {8'h00, m_ies};
            16'h1A: return {8'h00, m_ie};
            16'h1C: return {8'h00, m_ifg};
            default: return 16'h0000;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_step();
        logic [7:0]  pin, prv, edg, clr, nifg, wd;
        logic [15:0] o;
        bit          hit;
        if (reset) begin
            {m_out, m_dir, m_ren, m_sel, m_ies, m_ie, m_ifg} = '0;
            samp[0] = 0; samp[1] = 0; samp[2] = 0;
            return;
        end
        o   = bus_if.MAB - BASE;
        hit = (o < 16'd32);
        pin = samp[1];
        prv = samp[2];
        for (int n = 0; n < 8; n++)
            edg[n] = m_ies[n] ? (prv[n] && !pin[n]) : (pin[n] && !prv[n]);
        clr = 0;
        if (bus_if.MR && hit && (o & 16'hFFFE) == 16'h0E) begin
            for (int n = 7; n >= 0; n--)
                if (m_ie[n] && m_ifg[n]) clr = 8'h01 << n;
        end
        nifg = m_ifg & ~clr;
        wd   = bus_if.MDB_in[7:0];
        if (bus_if.MW && hit && !(bus_if.BW && o[0])) begin
            case (o & 16'hFFFE)
                16'h02: m_out = wd;
                16'h04: m_dir = wd;
                16'h06: m_ren = wd;
                16'h0A: m_sel = wd;
                16'h18: m_ies = wd;
                16'h1A: m_ie  = wd;
                16'h1C: nifg  = wd;
                default: ;
            endcase
        end
        m_ifg   = nifg | edg;
        samp[2] = samp[1];
        samp[1] = samp[0];
        samp[0] = pad_O;
    endtask

    task automatic tick();
        logic [7:0] ei, et;
        @(posedge MCLK);
        model_step();
        #1;
        for (int n = 0; n < 8; n++) begin
            ei[n] = m_sel[n] ? periph_out[n] : m_out[n];
            et[n] = m_sel[n] ? !periph_dir[n] : !m_dir[n];
        end
        chk("pad_I", {8'h00, pad_I}, {8'h00, ei});
        chk("pad_T", {8'h00, pad_T}, {8'h00, et});
        chk("pad_REN", {8'h00, pad_REN}, {8'h00, m_ren & ~m_dir & ~m_sel});
        chk("periph_in", {8'h00, periph_in}, {8'h00, samp[1]});
        chk("irq", {15'h0, irq}, {15'h0, |(m_ie & m_ifg)});
    endtask

    task automatic wr(logic [15:0] off, logic [15:0] d, logic bw = 1'b0);
        bus_if.MAB = BASE + off; bus_if.MDB_in = d; bus_if.MW = 1'b1; bus_if.BW = bw;
        tick();
        bus_if.MW = 1'b0; bus_if.BW = 1'b0;
    endtask

    task automatic rd_chk(string tag, logic [15:0] off, logic [15:0] exp);
        bus_if.MAB = BASE + off;
        #1;
        chk(tag, bus_if.MDB_out, exp);
    endtask

    task automatic iv_rd(string tag, logic [15:0] exp);
        bus_if.MAB = BASE + 16'h0E; bus_if.MR = 1'b1;
        #1;
        chk(tag, bus_if.MDB_out, exp);
        tick();
        bus_if.MR = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pad_O = 0; periph_out = 0; periph_dir = 0;
        bus_if.MAB = BASE + 16'h04; bus_if.MDB_in = 16'h00FF;
        bus_if.MW = 1'b1; bus_if.MR = 1'b0; bus_if.BW = 1'b0;
        // Reset wins over a concurrent write to PxDIR.
        tick(); tick();
        reset = 1'b0; bus_if.MW = 1'b0;
        chk("rst_pad_T", {8'h00, pad_T}, 16'h00FF);
        chk("rst_irq", {15'h0, irq}, 16'h0000);
        rd_chk("rst_dir", 16'h04, 16'h0000);
        rd_chk("rst_iv", 16'h0E, 16'h0000);
        rd_chk("rst_ifg", 16'h1C, 16'h0000);

        // Output drive and ignored odd-byte write.
        wr(16'h04, 16'h000F);
        wr(16'h02, 16'h00A5);
        chk("drv_pad_T", {8'h00, pad_T}, 16'h00F0);
        chk("drv_pad_I", {8'h00, pad_I}, 16'h00A5);
        wr(16'h03, 16'h003C, 1'b1);
        rd_chk("odd_byte", 16'h02, 16'h00A5);

        // Input latency: change before edge k, PxIN after k+1, IFG/irq after k+2.
        wr(16'h18, 16'h0002);
        wr(16'h1A, 16'h0003);
        pad_O = 8'h01;
        tick(); chk("lat_k", {8'h00, periph_in}, 16'h0000);
        tick(); chk("lat_k1_in", {8'h00, periph_in}, 16'h0001);
        chk("lat_k1_irq", {15'h0, irq}, 16'h0000);
        tick(); chk("lat_k2_irq", {15'h0, irq}, 16'h0001);
        rd_chk("lat_ifg", 16'h1C, 16'h0001);
        pad_O = 8'h03;
        tick(); tick(); tick();
        rd_chk("rise_b1", 16'h1C, 16'h0001);
        pad_O = 8'h01;
        tick(); tick(); tick();
        rd_chk("fall_b1", 16'h1C, 16'h0003);

        // PxIV priority and clear-on-read.
        wr(16'h1C, 16'h0024);
        wr(16'h1A, 16'h00FF);
        iv_rd("iv_first", 16'h0006);
        iv_rd("iv_second", 16'h000C);
        iv_rd("iv_third", 16'h0000);
        chk("iv_irq", {15'h0, irq}, 16'h0000);
        wr(16'h1C, 16'h0024);
        wr(16'h1A, 16'h0020);
        iv_rd("iv_ie20", 16'h000C);

        // Edge beats a concurrent software write of zero.
        wr(16'h1A, 16'h0000);
        wr(16'h18, 16'h0000);
        wr(16'h1C, 16'h0000);
        pad_O = 8'h09;
        tick(); tick();
        wr(16'h1C, 16'h0000);
        rd_chk("sim_wr", 16'h1C, 16'h0008);
        // Edge beats a concurrent PxIV clear.
        wr(16'h1A, 16'h0008);
        pad_O = 8'h01;
        tick(); tick(); tick();
        pad_O = 8'h09;
        tick(); tick();
        iv_rd("sim_iv", 16'h0008);
        rd_chk("sim_iv_ifg", 16'h1C, 16'h0008);

        // Peripheral override of pin 7.
        wr(16'h06, 16'h0080);
        wr(16'h0A, 16'h0080);
        periph_dir = 8'h80; periph_out = 8'h80;
        tick();
        chk("per_T7", {15'h0, pad_T[7]}, 16'h0000);
        chk("per_I7", {15'h0, pad_I[7]}, 16'h0001);
        chk("per_REN7", {15'h0, pad_REN[7]}, 16'h0000);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            bus_if.MAB = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                     : BASE + 16'($urandom_range(0, 31));
            bus_if.MDB_in = 16'($urandom);
            bus_if.MW = ($urandom_range(0, 2) == 0);
            bus_if.MR = ($urandom_range(0, 3) == 0);
            bus_if.BW = 1'($urandom);
            if ($urandom_range(0, 3) == 0) pad_O = pad_O ^ (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) begin
                periph_out = 8'($urandom); periph_dir = 8'($urandom);
            end
            #1;
            chk("rnd_rd", bus_if.MDB_out, m_read(bus_if.MAB));
            tick();
        end

        // Reset mid-operation with a pending flag and a concurrent write.
        reset = 1'b0; bus_if.MW = 1'b0; bus_if.MR = 1'b0;
        wr(16'h1A, 16'h00FF);
        wr(16'h1C, 16'h00FF);
        pad_O = 8'hFF;
        reset = 1'b1; bus_if.MAB = BASE + 16'h04; bus_if.MDB_in = 16'h00FF; bus_if.MW = 1'b1;
        tick();
        reset = 1'b0; bus_if.MW = 1'b0;
        chk("mid_rst_irq", {15'h0, irq}, 16'h0000);
        chk("mid_rst_in", {8'h00, periph_in}, 16'h0000);
        rd_chk("mid_rst_dir", 16'h04, 16'h0000);
        rd_chk("mid_rst_ifg", 16'h1C, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/gpio_port.md
# gpio_port

Memory-mapped 8-bit MSP430-style digital I/O port that sits directly upstream of the per-pin IOBUF tristate pads. It drives each pad's `I` (output value) and `T` (tristate, 1 = high-Z), and consumes each pad's `O` (pin level). The pin level passes through a two-flop synchronizer into PxIN. Edge-triggered interrupt flags, an IRQ line and a clear-on-read PxIV vector feed the interrupt controller. PxSEL0 hands individual pins to a peripheral.

## Interface
- `BASE`, 16'h0200: byte address of PxIN; all register offsets below are relative to it.
- `MCLK`  in  1: system clock; every flop updates on the rising edge.
- `reset`  in  1: synchronous, active-high; sampled on the rising MCLK edge.
- `MAB`  in  16: memory address bus (byte address).
- `MDB_in`  in  16: write data.
- `MW`  in  1: write strobe, qualified by an address hit.
- `MR`  in  1: read strobe; needed only for PxIV clear-on-read.
- `BW`  in  1: 1 = byte access, 0 = word access.
- `MDB_out`  out  16: read data, combinational; 16'h0000 when no register is hit.
- `pad_I`  out  8: to IOBUF `I`.
- `pad_T`  out  8: to IOBUF `T`; 1 = high-Z.
- `pad_O`  in  8: from IOBUF `O`; asynchronous.
- `pad_REN`  out  8: pull enable to the pad. Pull direction = `pad_I`.
- `periph_out`  in  8: peripheral output value, used for pins with SEL0 = 1.
- `periph_dir`  in  8: peripheral direction (1 = output), used for pins with SEL0 = 1.
- `periph_in`  out  8: synchronized pin level; equals PxIN.
- `irq`  out  1: OR of (PxIE & PxIFG).

## Operation
- Register offsets. Each register is 8 bits in the low byte; the high byte reads 0.
  - 0x00 PxIN: read-only.
  - 0x02 PxOUT
  - 0x04 PxDIR
  - 0x06 PxREN
  - 0x0A PxSEL0
  - 0x0E PxIV: read-only, clear-on-read.
  - 0x18 PxIES
  - 0x1A PxIE
  - 0x1C PxIFG
- Writes:
  - Word writes take `MDB_in[7:0]`.
  - Byte writes to an even address take `MDB_in[7:0]`.
  - Byte writes to an odd address are ignored.
  - Writes to PxIN, PxIV and unmapped offsets are ignored.
- Pad mux, per bit n:
  - SEL0[n] = 0: `pad_I` = OUT[n], `pad_T` = ~DIR[n].
  - SEL0[n] = 1: `pad_I` = periph_out[n], `pad_T` = ~periph_dir[n].
  - `pad_REN[n]` = REN[n] & ~DIR[n] & ~SEL0[n]; pulls are never enabled on a driven pin.
- Synchronizer: sync1 <= `pad_O`; PxIN <= sync1; prev <= PxIN.
- Edge detect:
  - rise = PxIN & ~prev; fall = ~PxIN & prev.
  - edge[n] = IES[n] ? fall[n] : rise[n].
- IFG:
  - Per bit: next = edge[n] | (IFG[n] & ~clr[n]), or the written value when PxIFG is written.
  - An edge in the same cycle as a software write or clear wins, so the flag is set.
  - Edges set IFG regardless of IE and regardless of SEL0.
  - Writing PxIES never sets IFG.
- PxIV:
  - Value = 2·(k+1), where k is the lowest-index bit with IE & IFG set; 0 if none.
  - A read of PxIV (`MR` asserted and address hit) clears IFG[k] at that edge.
  - That read returns the pre-clear value.
- Reset values, all zero: OUT, DIR, REN, SEL0, IES, IE, IFG, sync1, PxIN, prev.
  - Resulting outputs: `pad_T` = 8'hFF, `pad_I` = 0, `pad_REN` = 0, `irq` = 0, PxIV = 0, `periph_in` = 0.
  - Reset mid-operation discards pending flags and in-flight synchronizer state.
  - Reset takes priority over any simultaneous bus write.

## Timing
- Register write: visible on `pad_I`, `pad_T` and `pad_REN` one cycle after the write edge.
- Pin input:
  - A `pad_O` change sampled at edge k appears in PxIN after edge k+1 (2-cycle latency).
  - The corresponding IFG and `irq` are set after edge k+2 (3-cycle latency).
- Glitches shorter than one MCLK period may be missed.
- A pin toggling back and forth produces one IFG set per qualifying edge; flags do not count.
- `MDB_out` and `irq` are combinational from registers; no wait states.

## Test plan
- Reset: assert `reset` for 2 cycles while writing PxDIR = 8'hFF -> DIR stays 0, `pad_T` = 8'hFF, `irq` = 0, all reads return 0.
- Output drive:
  - Write PxDIR = 8'h0F, then PxOUT = 8'hA5 -> next cycle `pad_T` = 8'hF0, `pad_I` = 8'hA5.
  - Byte write of 8'h3C to BASE+0x03 -> PxOUT unchanged.
- Input latency and edges:
  - Set IES = 8'h02, IE = 8'h03.
  - Raise `pad_O[0]` before edge k -> PxIN[0] = 1 after k+1; IFG[0] and `irq` = 1 after k+2.
  - Raise then drop `pad_O[1]` -> IFG[1] sets only on the fall.
- PxIV priority and clear:
  - With IFG = 8'h24 and IE = 8'hFF: first read returns 6 and clears bit 2; next read returns 12; third read returns 0 and `irq` = 0.
  - With IE = 8'h20: the first read returns 12.
- Simultaneous events:
  - Write PxIFG = 0 in the same cycle a rising edge is detected on bit 3 (IES = 0) -> IFG[3] = 1.
  - A PxIV read clearing bit 3 concurrent with a new bit-3 edge -> IFG[3] remains 1.
- Peripheral override: SEL0 = 8'h80, periph_dir[7] = 1, periph_out[7] = 1, PxDIR[7] = 0 -> `pad_T[7]` = 0, `pad_I[7]` = 1, `pad_REN[7]` = 0 even with REN[7] = 1.
